decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Registered, parametrised successor to the combinational opcode decoder: sits at the ID/EX
//  boundary, decodes a 5-bit opcode into a control bundle and registers it for EX.
//  Adds pipeline valid/stall/flush handling, multi-cycle MUL/DIV issue with a busy counter,
//  and a HALT drain/resume state machine that gates PC increment.
// PARAMETERS
//  OPC_W        5   opcode width; opcode values come from the shared `defines in parameters.v
//  MUL_CYCLES   2   EX occupancy of MUL, in cycles (>=1)
//  DIV_CYCLES   8   EX occupancy of DIV, in cycles (>=1)
//  DRAIN_CYCLES 3   cycles after HALT issue before halted asserts (pipeline drain, >=1)
//  CNT_W        4   busy/drain counter width; must hold max(MUL,DIV,DRAIN)_CYCLES-1
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  opcode       in   OPC_W  opcode of the instruction in ID
//  id_valid     in   1      ID holds a real instruction
//  stall        in   1      hazard-unit stall: hold the EX bundle, do not accept ID
//  flush        in   1      branch/jump flush: EX bundle becomes a bubble next cycle
//  resume       in   1      leave HALTED (one-cycle pulse)
//  id_ready     out  1      ID instruction accepted this cycle (combinational)
//  pc_en        out  1      increment PC this cycle (combinational) = id_ready
//  ex_valid     out  1      registered: EX bundle is a real instruction
//  ex_alu_src, ex_read_write, ex_mem_write, ex_mem_to_reg, ex_mem_read   out 1   registered controls
//  ex_branch, ex_jump, ex_alu_op                                          out 1   registered controls
//  ex_write_mode  out  2    registered: 00 none, 01 low byte, 11 full/high
//  busy         out  1      registered: multi-cycle op occupying EX
//  halted       out  1      registered: core halted
// BEHAVIOUR
//  Reset: every registered output is 0, ex_write_mode=00, state=RUN, counters=0.
//  Decode table (combinational, then registered); all controls default 0:
//   ADD SUB DIV NOT AND OR XOR INC CMP RR RL SETB CLRB CPLB: rw=1 alu_op=1 wm=01
//   MUL: rw=1 alu_op=1 wm=11 | SETF CLRF CPLF: alu_op=1 | LOAD: rw=1 m2r=1 mem_read=1 wm=11
//   STORE: mem_write=1 | LBL LBH: rw=1 alu_src=1 wm=01 | MOV: rw=1 wm=01
//   JF: branch=1 jump=1 | LOADBR: rw=1 jump=1 wm=11 | MOVOUT MOVIN MOVB: rw=1
//   NOP, HALT, undefined opcodes: all controls 0 (bubble with ex_valid=1 for NOP/HALT/undefined)
//  id_ready = (state==RUN) & ~stall & ~busy & ~flush & id_valid.
//  EX register update priority per cycle: rst > flush (bubble: ex_valid=0, controls 0)
//   > stall or busy (hold) > id_ready (load decoded bundle, ex_valid=1) > else bubble.
//  Latency: opcode accepted in cycle N -> bundle visible on ex_* in cycle N+1.
//  Multi-cycle: accepting MUL (DIV) loads cnt=MUL_CYCLES-1 (DIV_CYCLES-1); busy=1 while cnt!=0,
//   cnt decrements each cycle; the bundle is held on ex_* for the full occupancy; stall does
//   not freeze cnt. Parameter value 1 gives busy never asserted (single-cycle).
//   Flush while busy: cnt cleared, busy=0 next cycle, bundle bubbled.
//  FSM states: RUN, DRAIN, HALTED.
//   RUN -> DRAIN when HALT accepted; cnt loads DRAIN_CYCLES-1; id_ready=0 from next cycle.
//   DRAIN -> HALTED when cnt==0; halted=1 on entry. flush during DRAIN: ignored (HALT commits).
//   HALTED -> RUN on resume; resume in RUN/DRAIN ignored. halted=0 the cycle after resume.
//   HALT issued while busy is impossible (id_ready=0 while busy).
//  stall and flush together: flush wins. rst mid-MUL/DIV/DRAIN: immediate return to reset state.
// STRUCTURE
//  Opcode `defines and the write_mode codes (WM_NONE/WM_LOW/WM_FULL) live in shared parameters.v.
//  One sub-module: decode_ctrl_comb (pure opcode -> control-bundle table); this module owns
//  the EX register, counter and FSM.
// TESTING
//  rst=1 2 cycles, then ADD with id_valid=1 -> cycle+1: ex_valid=1 rw=1 alu_op=1 wm=01, pc_en=1.
//  MUL with MUL_CYCLES=2, then ADD next -> busy=1 for 1 cycle, id_ready=0, ADD issues 2 cycles after MUL.
//  DIV with DIV_CYCLES=8 and flush 3 cycles later -> busy=0, ex_valid=0 next cycle, pc_en resumes.
//  LOAD with stall=1 for 2 cycles -> ex_* hold previous bundle, pc_en=0; LOAD appears 1 cycle after release.
//  HALT, DRAIN_CYCLES=3 -> pc_en=0 thereafter, halted=1 3 cycles after HALT enters EX; resume -> RUN.
//  stall=1 and flush=1 together with JF in ID -> ex_valid=0, JF not accepted, pc_en=0.

Source files
------------

// File: rtl/decode_ctrl_pipe_pkg.sv
// Package for the ID/EX control pipeline register.
// Holds the opcode encodings, the write-mode codes, the registered control
// bundle type and the halt/drain state encoding shared by the decoder,
// the pipeline top and the testbench.
package decode_ctrl_pipe_pkg;

    // Opcode encodings; must stay in lock-step with the assembler table.
    // Codes 30 and 31 are unassigned and decode as a bubble.
    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_ADD    = 5'd1;
    localparam logic [4:0] OP_SUB    = 5'd2;
    localparam logic [4:0] OP_MUL    = 5'd3;
    localparam logic [4:0] OP_DIV    = 5'd4;
    localparam logic [4:0] OP_NOT    = 5'd5;
    localparam logic [4:0] OP_AND    = 5'd6;
    localparam logic [4:0] OP_OR     = 5'd7;
    localparam logic [4:0] OP_XOR    = 5'd8;
    localparam logic [4:0] OP_INC    = 5'd9;
    localparam logic [4:0] OP_CMP    = 5'd10;
    localparam logic [4:0] OP_RR     = 5'd11;
    localparam logic [4:0] OP_RL     = 5'd12;
    localparam logic [4:0] OP_SETB   = 5'd13;
    localparam logic [4:0] OP_CLRB   = 5'd14;
    localparam logic [4:0] OP_CPLB   = 5'd15;
    localparam logic [4:0] OP_SETF   = 5'd16;
    localparam logic [4:0] OP_CLRF   = 5'd17;
    localparam logic [4:0] OP_CPLF   = 5'd18;
    localparam logic [4:0] OP_LOAD   = 5'd19;
    localparam logic [4:0] OP_STORE  = 5'd20;
    localparam logic [4:0] OP_LBL    = 5'd21;
    localparam logic [4:0] OP_LBH    = 5'd22;
    localparam logic [4:0] OP_MOV    = 5'd23;
    localparam logic [4:0] OP_JF     = 5'd24;
    localparam logic [4:0] OP_LOADBR = 5'd25;
    localparam logic [4:0] OP_MOVOUT = 5'd26;
    localparam logic [4:0] OP_MOVIN  = 5'd27;
    localparam logic [4:0] OP_MOVB   = 5'd28;
    localparam logic [4:0] OP_HALT   = 5'd29;

    // Register-file write modes.
    localparam logic [1:0] WM_NONE = 2'b00;
    localparam logic [1:0] WM_LOW  = 2'b01;
    localparam logic [1:0] WM_FULL = 2'b11;

    typedef struct packed {
        logic       alu_src;
        logic       read_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       alu_op;
        logic [1:0] write_mode;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: '0};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Builds a control bundle from its fields.
    function automatic ctrl_t mk_ctrl(
        input logic       alu_src,
        input logic       read_write,
        input logic       mem_write,
        input logic       mem_to_reg,
        input logic       mem_read,
        input logic       branch,
        input logic       jump,
        input logic       alu_op,
        input logic [1:0] write_mode
    );
        ctrl_t c;
        c.alu_src    = alu_src;
        c.read_write = read_write;
        c.mem_write  = mem_write;
        c.mem_to_reg = mem_to_reg;
        c.mem_read   = mem_read;
        c.branch     = branch;
        c.jump       = jump;
        c.alu_op     = alu_op;
        c.write_mode = write_mode;
        return c;
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Interface bundling the ID-side handshake and the registered EX control
// bundle of decode_ctrl_pipe.
//   master : the ID stage / hazard unit side (drives opcode, id_valid,
//            stall, flush, resume; observes everything else)
//   slave  : decode_ctrl_pipe itself
interface decode_ctrl_pipe_if #(
    parameter int OPC_W = 5
);
    logic [OPC_W-1:0] opcode;
    logic             id_valid;
    logic             stall;
    logic             flush;
    logic             resume;
    logic             id_ready;
    logic             pc_en;
    logic             ex_valid;
    logic             ex_alu_src;
    logic             ex_read_write;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_mem_read;
    logic             ex_branch;
    logic             ex_jump;
    logic             ex_alu_op;
    logic [1:0]       ex_write_mode;
    logic             busy;
    logic             halted;

    modport master (
        output opcode, id_valid, stall, flush, resume,
        input  id_ready, pc_en, ex_valid,
        input  ex_alu_src, ex_read_write, ex_mem_write, ex_mem_to_reg,
        input  ex_mem_read, ex_branch, ex_jump, ex_alu_op, ex_write_mode,
        input  busy, halted
    );

    modport slave (
        input  opcode, id_valid, stall, flush, resume,
        output id_ready, pc_en, ex_valid,
        output ex_alu_src, ex_read_write, ex_mem_write, ex_mem_to_reg,
        output ex_mem_read, ex_branch, ex_jump, ex_alu_op, ex_write_mode,
        output busy, halted
    );
endinterface

// File: rtl/decode_ctrl_pipe_comb.sv
// decode_ctrl_comb: pure opcode -> control bundle table, no state.
// Ports:
//   i_opcode  in   OPC_W   opcode currently in ID
//   o_ctrl    out  ctrl_t  decoded controls (all zero for NOP/HALT/unassigned)
module decode_ctrl_comb
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    output ctrl_t            o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_opcode)
            OPC_W'(OP_ADD),  OPC_W'(OP_SUB),  OPC_W'(OP_DIV),  OPC_W'(OP_NOT),
            OPC_W'(OP_AND),  OPC_W'(OP_OR),   OPC_W'(OP_XOR),  OPC_W'(OP_INC),
            OPC_W'(OP_CMP),  OPC_W'(OP_RR),   OPC_W'(OP_RL),   OPC_W'(OP_SETB),
            OPC_W'(OP_CLRB), OPC_W'(OP_CPLB):
                o_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WM_LOW);
            OPC_W'(OP_MUL):
                o_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WM_FULL);
            OPC_W'(OP_SETF), OPC_W'(OP_CLRF), OPC_W'(OP_CPLF):
                o_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WM_NONE);
            OPC_W'(OP_LOAD):
                o_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, WM_FULL);
            OPC_W'(OP_STORE):
                o_ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WM_NONE);
            OPC_W'(OP_LBL), OPC_W'(OP_LBH):
                o_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WM_LOW);
            OPC_W'(OP_MOV):
                o_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WM_LOW);
            OPC_W'(OP_JF):
                o_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, WM_NONE);
            OPC_W'(OP_LOADBR):
                o_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, WM_FULL);
            // Register-moves write through a path that does not use write_mode.
            OPC_W'(OP_MOVOUT), OPC_W'(OP_MOVIN), OPC_W'(OP_MOVB):
                o_ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WM_NONE);
            default:
                o_ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: ID/EX control register with valid/stall/flush handling,
// multi-cycle MUL/DIV occupancy and a HALT drain/resume sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; cnt counts down MUL/DIV occupancy (busy)
// DRAIN   | HALT issued, no further issue; cnt counts pipeline drain
// HALTED  | core stopped, halted=1; resume pulse returns to RUN
//
// Ports:
//   i_clk   in   1   clock, rising edge
//   i_rst   in   1   synchronous active-high reset
//   bus     slave    handshake, EX control bundle, busy/halted status
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int OPC_W        = 5,
    parameter int MUL_CYCLES   = 2,
    parameter int DIV_CYCLES   = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    decode_ctrl_pipe_if.slave   bus
);

    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             r_halted;
    logic             r_ex_valid;
    ctrl_t            r_ex;
    ctrl_t            w_ctrl;
    logic             w_id_ready;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_halt;

    decode_ctrl_comb #(
        .OPC_W (OPC_W)
    ) u_comb (
        .i_opcode (bus.opcode),
        .o_ctrl   (w_ctrl)
    );

    assign w_is_mul  = (bus.opcode == OPC_W'(OP_MUL));
    assign w_is_div  = (bus.opcode == OPC_W'(OP_DIV));
    assign w_is_halt = (bus.opcode == OPC_W'(OP_HALT));

    assign w_id_ready = (r_state == ST_RUN) & ~bus.stall & ~r_busy & ~bus.flush & bus.id_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                // Flush kills an in-flight multi-cycle op; stall does not freeze it.
                if (bus.flush) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
                // id_ready implies busy=0, so cnt is already zero here.
                if (w_id_ready) begin
                    if (w_is_halt) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = DRAIN_LOAD;
                    end else if (w_is_mul) begin
                        w_cnt_nxt = MUL_LOAD;
                    end else if (w_is_div) begin
                        w_cnt_nxt = DIV_LOAD;
                    end
                end
            end
            // Flush is deliberately not looked at: once HALT is issued it commits.
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (bus.resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            // The shared counter only means "EX occupied" while running.
            r_busy   <= (w_state_nxt == ST_RUN) && (w_cnt_nxt != '0);
            r_halted <= (w_state_nxt == ST_HALTED);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_valid <= 1'b0;
            r_ex       <= CTRL_NONE;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
            r_ex       <= CTRL_NONE;
        end else if (bus.stall || r_busy) begin
            r_ex_valid <= r_ex_valid;
            r_ex       <= r_ex;
        end else if (w_id_ready) begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_ctrl;
        end else begin
            r_ex_valid <= 1'b0;
            r_ex       <= CTRL_NONE;
        end
    end

    assign bus.id_ready      = w_id_ready;
    assign bus.pc_en         = w_id_ready;
    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_alu_src    = r_ex.alu_src;
    assign bus.ex_read_write = r_ex.read_write;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_branch     = r_ex.branch;
    assign bus.ex_jump       = r_ex.jump;
    assign bus.ex_alu_op     = r_ex.alu_op;
    assign bus.ex_write_mode = r_ex.write_mode;
    assign bus.busy          = r_busy;
    assign bus.halted        = r_halted;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe (default parameters:
// MUL_CYCLES=2, DIV_CYCLES=8, DRAIN_CYCLES=3).
// Bundle packing used below: {alu_src, rw, mem_write, mem_to_reg, mem_read,
// branch, jump, alu_op, write_mode[1:0]}.
module tb_decode_ctrl_pipe;
    import decode_ctrl_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    decode_ctrl_pipe_if #(.OPC_W(5)) bus ();

    decode_ctrl_pipe #(
        .OPC_W(5), .MUL_CYCLES(2), .DIV_CYCLES(8), .DRAIN_CYCLES(3), .CNT_W(4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic logic [9:0] model(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_DIV, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC,
            OP_CMP, OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB: return 10'b0100000101;
            OP_MUL:                          return 10'b0100000111;
            OP_SETF, OP_CLRF, OP_CPLF:       return 10'b0000000100;
            OP_LOAD:                         return 10'b0101100011;
            OP_STORE:                        return 10'b0010000000;
            OP_LBL, OP_LBH:                  return 10'b1100000001;
            OP_MOV:                          return 10'b0100000001;
            OP_JF:                           return 10'b0000011000;
            OP_LOADBR:                       return 10'b0100001011;
            OP_MOVOUT, OP_MOVIN, OP_MOVB:    return 10'b0100000000;
            default:                         return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [9:0] dut_bundle();
        return {bus.ex_alu_src, bus.ex_read_write, bus.ex_mem_write, bus.ex_mem_to_reg,
                bus.ex_mem_read, bus.ex_branch, bus.ex_jump, bus.ex_alu_op, bus.ex_write_mode};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1; bus.id_valid = 1'b0; bus.opcode = OP_ADD;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.resume = 1'b0;
        tick(); tick();
        got = dut_bundle();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid); end
        checks++; if (got !== 10'h0) begin errors++; $display("FAIL reset_bundle: got %b expected 0000000000", got); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [4:0] ops [12];
        logic [9:0] exp, got;
        ops = '{OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_LBH, OP_JF,
                OP_LOADBR, OP_MOVB, OP_CPLF, OP_NOP, 5'd31, OP_MOV};
        for (int i = 0; i < 12; i++) begin
            bus.opcode = ops[i]; bus.id_valid = 1'b1;
            #1;
            checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL decode_pc_en op=%0d: got %b expected 1", ops[i], bus.pc_en); end
            exp_q.push_back(model(ops[i]));
            tick();
            exp = exp_q.pop_front();
            got = dut_bundle();
            checks++; if (got !== exp) begin errors++; $display("FAIL decode_bundle op=%0d: got %b expected %b", ops[i], got, exp); end
            checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL decode_ex_valid op=%0d: got %b expected 1", ops[i], bus.ex_valid); end
        end
        bus.id_valid = 1'b0;
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble: got %b expected 0", bus.ex_valid); end
    endtask

    task automatic test_mul();
        logic [9:0] exp, got;
        bus.opcode = OP_MUL; bus.id_valid = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL mul_accept: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_MUL));
        tick();
        got = dut_bundle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b expected 1", bus.busy); end
        checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL mul_bundle: got %b expected %b", got, exp_q[0]); end
        bus.opcode = OP_ADD;
        #1;
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL mul_id_ready_busy: got %b expected 0", bus.id_ready); end
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b expected 0", bus.busy); end
        checks++; if (got !== exp) begin errors++; $display("FAIL mul_hold: got %b expected %b", got, exp); end
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL mul_add_accept: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_ADD));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL mul_add_bundle: got %b expected %b", got, exp); end
    endtask

    task automatic test_div_flush();
        logic [9:0] exp, got;
        bus.opcode = OP_DIV; bus.id_valid = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL div_accept: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_DIV));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL div_bundle: got %b expected %b", got, exp); end
        bus.opcode = OP_ADD;
        for (int c = 0; c < 2; c++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL div_busy c=%0d: got %b expected 1", c, bus.busy); end
            tick();
        end
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL div_flush_pc_en: got %b expected 0", bus.pc_en); end
        tick();
        bus.flush = 1'b0;
        got = dut_bundle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div_flush_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.ex_valid !== 1'b0 || got !== 10'h0) begin errors++; $display("FAIL div_flush_bubble: got valid=%b bundle=%b expected 0/0", bus.ex_valid, got); end
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL div_pc_en_resume: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_ADD));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL div_after_add: got %b expected %b", got, exp); end
    endtask

    task automatic test_stall();
        logic [9:0] exp, got;
        bus.opcode = OP_SETB; bus.id_valid = 1'b1;
        exp_q.push_back(model(OP_SETB));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL stall_prev: got %b expected %b", got, exp); end
        bus.opcode = OP_LOAD; bus.stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL stall_pc_en c=%0d: got %b expected 0", c, bus.pc_en); end
            tick();
            got = dut_bundle();
            checks++; if (got !== exp || bus.ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold c=%0d: got %b/%b expected %b/1", c, got, bus.ex_valid, exp); end
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL stall_release_pc_en: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_LOAD));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL stall_load: got %b expected %b", got, exp); end
    endtask

    task automatic test_stall_flush();
        logic [9:0] got;
        bus.opcode = OP_JF; bus.id_valid = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL sf_pc_en: got %b expected 0", bus.pc_en); end
        tick();
        got = dut_bundle();
        checks++; if (bus.ex_valid !== 1'b0 || got !== 10'h0) begin errors++; $display("FAIL sf_bubble: got valid=%b bundle=%b expected 0/0", bus.ex_valid, got); end
        bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        tick();
        got = dut_bundle();
        checks++; if (bus.ex_valid !== 1'b0 || got !== 10'h0) begin errors++; $display("FAIL sf_jf_not_taken: got valid=%b bundle=%b expected 0/0", bus.ex_valid, got); end
    endtask

    task automatic test_halt();
        logic [9:0] exp, got;
        int n;
        bit seen;
        bus.id_valid = 1'b0; bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_in_run: got %b expected 0", bus.halted); end
        bus.opcode = OP_HALT; bus.id_valid = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL halt_accept: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_HALT));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp || bus.ex_valid !== 1'b1) begin errors++; $display("FAIL halt_in_ex: got %b/%b expected %b/1", got, bus.ex_valid, exp); end
        bus.opcode = OP_ADD;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            bus.flush = (n == 0);
            #1;
            checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL drain_pc_en n=%0d: got %b expected 0", n, bus.pc_en); end
            tick();
            n++;
            if (bus.halted === 1'b1) seen = 1'b1;
        end
        bus.flush = 1'b0;
        checks++; if (!seen || n != 3) begin errors++; $display("FAIL halt_latency: got %0d cycles (seen=%b) expected 3", n, seen); end
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL halted_pc_en: got %b expected 0", bus.pc_en); end
        tick();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halted_stays: got %b expected 1", bus.halted); end
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b expected 0", bus.halted); end
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL resume_pc_en: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_ADD));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL resume_add: got %b expected %b", got, exp); end
    endtask

    task automatic test_rst_mid();
        logic [9:0] exp, got;
        bus.opcode = OP_DIV; bus.id_valid = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", bus.busy); end
        rst = 1'b1; bus.opcode = OP_ADD;
        tick();
        rst = 1'b0;
        got = dut_bundle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_clr: got %b expected 0", bus.busy); end
        checks++; if (bus.ex_valid !== 1'b0 || got !== 10'h0) begin errors++; $display("FAIL rst_mid_bubble: got valid=%b bundle=%b expected 0/0", bus.ex_valid, got); end
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pc_en: got %b expected 1", bus.pc_en); end
        exp_q.push_back(model(OP_ADD));
        tick();
        exp = exp_q.pop_front();
        got = dut_bundle();
        checks++; if (got !== exp) begin errors++; $display("FAIL rst_mid_add: got %b expected %b", got, exp); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.opcode = OP_NOP; bus.id_valid = 1'b0; bus.stall = 1'b0;
        bus.flush = 1'b0; bus.resume = 1'b0;
        test_reset();
        test_decode();
        test_mul();
        test_div_flush();
        test_stall();
        test_stall_flush();
        test_halt();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
